// File: rtl/bit_reversal_reorder_pkg.sv
// Shared definitions for the bit-reversal reorder buffer.
//   depth_of(n)      : frame length 2^n for an n-bit index.
//   bitrev(value, n) : reverses the low n bits of value (bit k <- bit n-1-k).
//                      This is a constant function, so it can be used in
//                      elaboration-time expressions and in reference models.
package bit_reversal_pkg;

  localparam int DEFAULT_N     = 3;
  localparam int DEFAULT_DEPTH = 1 << DEFAULT_N;

  function automatic int depth_of(input int n);
    return 1 << n;
  endfunction

  function automatic int unsigned bitrev(input int unsigned value, input int n);
    int unsigned r;
    r = 0;
    for (int k = 0; k < n; k++) begin
      r[k] = value[n-1-k];
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_reversal_reorder_bitrev_index.sv
// Combinational N-bit index reverser.
//   idx     : natural-order index
//   rev_idx : idx with bit order mirrored (rev_idx[k] = idx[N-1-k])
module bitrev_index #(
  parameter int N = 3
) (
  input  logic [N-1:0] idx,
  output logic [N-1:0] rev_idx
);

  for (genvar k = 0; k < N; k++) begin : g_rev
    assign rev_idx[k] = idx[N-1-k];
  end

endmodule

// File: rtl/bit_reversal_reorder.sv
// Streaming frame reorder buffer with ping-pong banks.
// Accepts frames of 2^N samples in natural order and emits each frame either
// bit-reversed or unchanged; the mode is captured with the first sample.
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : input sample valid        in_ready : input may be accepted
//   in_data    : input sample (W bits)     rev_en   : frame mode, first sample only
//   out_valid  : output sample valid       out_ready: downstream accepts
//   out_data   : output sample (0 when idle)
//   out_last   : final sample of the frame
module bit_reversal_reorder
  import bit_reversal_pkg::*;
#(
  parameter int N = 3,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         rev_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last
);

  localparam int DEPTH = depth_of(N);

  logic [W-1:0] mem [2][DEPTH];
  logic [1:0]   full;
  logic [1:0]   mode;
  logic         wr_bank;
  logic         rd_bank;
  logic [N-1:0] wr_cnt;
  logic [N-1:0] rd_cnt;
  logic [N-1:0] rev_cnt;
  logic [N-1:0] rd_addr;
  logic         wr_fire;
  logic         rd_fire;

  bitrev_index #(.N(N)) u_bitrev (
    .idx     (rd_cnt),
    .rev_idx (rev_cnt)
  );

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign rd_addr   = mode[rd_bank] ? rev_cnt : rd_cnt;
  assign out_data  = out_valid ? mem[rd_bank][rd_addr] : '0;
  assign out_last  = out_valid && (&rd_cnt);

  assign wr_fire = in_valid && in_ready;
  assign rd_fire = out_valid && out_ready;

  // Control: counters, bank pointers, full/mode flags.
  // Counters wrap naturally at DEPTH, so they simply increment on every
  // handshake. A write completion and a read completion in the same cycle
  // always touch different banks (writes never target a full bank).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_bank <= 1'b0;
      rd_cnt  <= '0;
      full    <= 2'b00;
      mode    <= 2'b00;
    end else begin
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (wr_cnt == '0) begin
          mode[wr_bank] <= rev_en;
        end
        if (&wr_cnt) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
        end
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 1'b1;
        if (out_last) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
        end
      end
    end
  end

  // Datapath: sample storage, intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_bank][wr_cnt] <= in_data;
    end
  end

endmodule

// File: tb/tb_bit_reversal_reorder.sv
// Self-checking bench for bit_reversal_reorder: directed scenarios plus
// randomized traffic against a frame-level reference model.
module tb_bit_reversal_reorder;
  import bit_reversal_pkg::*;

  localparam int N     = 3;
  localparam int W     = 8;
  localparam int DEPTH = depth_of(N);

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         rev_en;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  bit_reversal_reorder #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .rev_en    (rev_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  // Reference model: collect a frame, then emit it in the chosen order.
  logic [W-1:0] part_q[$];
  logic         part_mode;
  exp_t         exp_q[$];
  int           full_frames;

  logic [W-1:0] got_q[$];
  int vec_cnt;
  int err_cnt;
  int cyc;
  int first_acc;
  int first_vld;
  logic last_in_ready;
  logic last_out_valid;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    part_q.delete();
    exp_q.delete();
    full_frames = 0;
    part_mode   = 1'b0;
  endtask

  // Called at a negedge: apply inputs, check outputs, advance model, step one cycle.
  task automatic drive_cycle(input logic iv, input logic [W-1:0] d, input logic re,
                             input logic ordy, output logic accepted);
    logic mr;
    logic mv;
    exp_t e;
    in_valid  = iv;
    in_data   = d;
    rev_en    = re;
    out_ready = ordy;
    mr = (full_frames < 2);
    mv = (exp_q.size() > 0);
    last_in_ready  = in_ready;
    last_out_valid = out_valid;
    check_val("in_ready", in_ready, mr);
    check_val("out_valid", out_valid, mv);
    if (mv) begin
      check_val("out_data", out_data, exp_q[0].data);
      check_val("out_last", out_last, exp_q[0].last);
    end else begin
      check_val("idle_out_data", out_data, 0);
      check_val("idle_out_last", out_last, 0);
    end
    if (first_vld < 0 && out_valid) first_vld = cyc;
    accepted = iv && mr;
    if (first_acc < 0 && accepted) first_acc = cyc;
    if (mv && ordy) begin
      got_q.push_back(out_data);
      e = exp_q.pop_front();
      if (e.last) full_frames--;
    end
    if (accepted) begin
      if (part_q.size() == 0) part_mode = re;
      part_q.push_back(d);
      if (part_q.size() == DEPTH) begin
        for (int k = 0; k < DEPTH; k++) begin
          e.data = part_mode ? part_q[bitrev(k, N)] : part_q[k];
          e.last = (k == DEPTH - 1);
          exp_q.push_back(e);
        end
        part_q.delete();
        full_frames++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] d, input logic re, input logic ordy);
    logic acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    while (!acc && guard < 100) begin
      drive_cycle(1'b1, d, re, ordy, acc);
      guard++;
    end
    if (!acc) check_val("send_timeout", guard, 0);
  endtask

  task automatic drain();
    logic acc;
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      drive_cycle(1'b0, '0, 1'b0, 1'b1, acc);
      guard++;
    end
    check_val("drain_left", exp_q.size(), 0);
    drive_cycle(1'b0, '0, 1'b0, 1'b1, acc);
  endtask

  logic [W-1:0] t_rev[8];
  logic [W-1:0] t_two[16];

  initial begin
    logic acc;
    int zero_rdy;
    int gaps;
    int accepted_cnt;
    int guard;

    t_rev = '{8'd0, 8'd4, 8'd2, 8'd6, 8'd1, 8'd5, 8'd3, 8'd7};
    t_two = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
              8'd20, 8'd24, 8'd22, 8'd26, 8'd21, 8'd25, 8'd23, 8'd27};
    vec_cnt = 0; err_cnt = 0; cyc = 0;
    first_acc = -1; first_vld = -1;
    in_valid = 0; in_data = '0; rev_en = 0; out_ready = 0;
    model_reset();

    // Reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_last", out_last, 0);
    rst = 1'b0;
    @(negedge clk);

    // Reverse mode, frame 0..7
    got_q.delete();
    first_acc = -1; first_vld = -1;
    for (int i = 0; i < DEPTH; i++) send(W'(i), 1'b1, 1'b1);
    drain();
    check_val("latency", first_vld - first_acc, DEPTH);
    check_val("t1_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check_val("t1_order", got_q[i], t_rev[i]);

    // Natural frame then reversed frame, rev_en toggling mid-frame
    got_q.delete();
    for (int i = 0; i < DEPTH; i++) send(W'(10 + i), (i == 0) ? 1'b0 : 1'($urandom), 1'b1);
    for (int i = 0; i < DEPTH; i++) send(W'(20 + i), (i == 0) ? 1'b1 : 1'($urandom), 1'b1);
    drain();
    check_val("t2_count", got_q.size(), 16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) check_val("t2_order", got_q[i], t_two[i]);

    // Backpressure
    for (int i = 0; i < 2 * DEPTH; i++) send(W'(100 + i), 1'b0, 1'b0);
    drive_cycle(1'b1, 8'hEE, 1'b0, 1'b0, acc);
    check_val("bp_stall_ready", last_in_ready, 0);
    drive_cycle(1'b1, 8'hEE, 1'b0, 1'b1, acc);
    check_val("bp_pulse_accept", acc, 0);
    drive_cycle(1'b1, 8'hEE, 1'b0, 1'b0, acc);
    check_val("bp_ready_after_pulse", last_in_ready, 0);
    for (int i = 0; i < DEPTH - 1; i++) drive_cycle(1'b0, '0, 1'b0, 1'b1, acc);
    drive_cycle(1'b0, '0, 1'b0, 1'b0, acc);
    check_val("bp_ready_release", last_in_ready, 1);
    drain();

    // Continuous streaming, 4 frames
    zero_rdy = 0; gaps = 0;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      send(W'($urandom), 1'($urandom), 1'b1);
      if (!last_in_ready) zero_rdy++;
      if (i >= DEPTH && !last_out_valid) gaps++;
    end
    drain();
    check_val("stream_ready_drops", zero_rdy, 0);
    check_val("stream_valid_gaps", gaps, 0);

    // Random stalls, 50 frames
    accepted_cnt = 0; guard = 0;
    while (accepted_cnt < 50 * DEPTH && guard < 5000) begin
      drive_cycle(1'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), acc);
      if (acc) accepted_cnt++;
      guard++;
    end
    check_val("rand_accepted", accepted_cnt, 50 * DEPTH);
    drain();

    // Reset mid-operation
    for (int i = 0; i < DEPTH; i++) send(W'(50 + i), 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) send(W'(60 + i), 1'b1, 1'b1);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_val("mid_rst_out_valid", out_valid, 0);
    check_val("mid_rst_out_data", out_data, 0);
    check_val("mid_rst_in_ready", in_ready, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    got_q.delete();
    for (int i = 0; i < DEPTH; i++) send(W'(i), 1'b1, 1'b1);
    drain();
    check_val("t6_count", got_q.size(), 8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) check_val("t6_order", got_q[i], t_rev[i]);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/bit_reversal_reorder.md
# bit_reversal_reorder

Streaming, parametrised successor to the combinational bit reverser. It accepts frames of 2^N samples in natural order and emits each frame either in bit-reversed index order or unchanged, with the mode selected per frame. Two ping-pong banks give continuous one-sample-per-cycle throughput. It sits between a sample source and FFT or permutation stages, with valid/ready handshakes on both sides.

## Interface
- N, default 3: log2 of the frame length; legal range N >= 1; DEPTH = 2^N.
- W, default 8: sample width in bits.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input may be accepted.
- in_data  in  W  input sample.
- rev_en  in  1  frame mode (1 = bit-reversed output, 0 = natural order); sampled only with the first sample of a frame.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  W  output sample.
- out_last  out  1  high with the final sample of a frame.

## Operation
- Storage: two banks of DEPTH x W registers. Per-bank state: full flag and mode bit. Storage contents are not reset.
- Write side state: wr_bank (1 bit) and wr_cnt (N bits).
- in_ready = !full[wr_bank].
- On each input handshake (in_valid && in_ready):
  - Store in_data at bank[wr_bank][wr_cnt].
  - If wr_cnt == 0, latch rev_en into mode[wr_bank].
  - If wr_cnt == DEPTH-1: set full[wr_bank], toggle wr_bank, wrap wr_cnt to 0. Otherwise increment wr_cnt.
- Read side state: rd_bank (1 bit) and rd_cnt (N bits).
- Read address: if mode[rd_bank] = 1, use bitrev(rd_cnt), where output bit k = rd_cnt bit N-1-k. Otherwise use rd_cnt.
- Output signals:
  - out_valid = full[rd_bank].
  - out_data = bank[rd_bank][addr] when out_valid, else 0.
  - out_last = out_valid && rd_cnt == DEPTH-1.
- On each output handshake:
  - If out_last: clear full[rd_bank], toggle rd_bank, wrap rd_cnt to 0.
  - Otherwise increment rd_cnt.
- Simultaneous events: write completion into one bank and read completion from the other bank in the same cycle are both applied. Writes never target a full bank, so a same-bank read/write conflict cannot occur.
- rev_en on non-first samples is ignored. In_data while in_ready is low is ignored.

## Timing
- Reset values (asynchronous): wr_bank=0, wr_cnt=0, rd_bank=0, rd_cnt=0, full=2'b00, mode=2'b00. Outputs: in_ready=1, out_valid=0, out_data=0, out_last=0.
- Reset mid-frame discards all partial and full frames. The first handshake after reset deassertion starts a new frame in bank 0.
- Latency: the last sample of a frame is accepted at edge t. out_valid is high in the cycle following edge t, and the first output sample is presented that cycle. First-in to first-out latency is DEPTH cycles minimum.
- Throughput: with in_valid and out_ready held high, in_ready never drops, and out_valid is continuous from cycle DEPTH onward, one sample per cycle.
- Backpressure: with out_ready low, in_ready falls after 2*DEPTH accepted samples. It rises the cycle after the last handshake of the frame being read.
- Outputs out_valid, out_last and out_data are combinational from registered state, with no input-to-output combinational path. in_ready depends only on registered state.

## Structure
- Shared package/include `bit_reversal_pkg`:
  - DEPTH localparam derivation.
  - A constant function `bitrev(value, N)`, reused by the bench's reference model.
- One sub-module, `bitrev_index`: a parametrised N-bit combinational index reverser instantiated on the read address.
- Top level contains:
  - Write and read counter/bank-pointer logic.
  - Full and mode flags.
  - The two register banks.

## Test plan
- Reverse mode, N=3: frame 0..7 with rev_en=1 and out_ready=1 → out 0,4,2,6,1,5,3,7; out_last only on the 7; first out_valid 8 cycles after the first accept.
- Natural mode: frame 10..17 with rev_en=0 → out 10..17 unchanged. Next frame 20..27 with rev_en=1 → 20,24,22,26,21,25,23,27. Shows per-frame mode and that rev_en toggled mid-frame is ignored.
- Backpressure: out_ready=0 and in_valid=1 continuously → 16 accepts, then in_ready=0. One out_ready pulse → out_data = first sample of frame 0, and in_ready stays 0. After 8 output handshakes → in_ready=1 the next cycle.
- Continuous streaming: 4 back-to-back frames, out_ready=1 → in_ready never low, no gaps in out_valid after cycle 8, all 32 samples match the model.
- Random stalls: random in_valid/out_ready, 50 frames, random modes → output sequence matches a scoreboard; no lost or duplicated samples.
- Reset mid-operation: assert rst after 5 samples of frame 1 while frame 0 is half read → immediately out_valid=0, out_data=0, in_ready=1. The next full frame 0..7 (rev) → 0,4,2,6,1,5,3,7.
